// File: rtl/flip_update_sched.sv
// Stochastic weight-flip scheduler: walks a flip vector chunk by chunk and
// read-modify-writes each BRAM word with flip & LFSR keep-mask.
module flip_update_sched #(
    parameter int          W_SIZE       = 3072,
    parameter int          CHUNK        = 64,
    parameter int          BRAM_LATENCY = 2,
    parameter logic [31:0] RANDOM_SEED  = 32'd1212
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              flip_valid_in,
    output logic                              flip_ready_out,
    input  logic [W_SIZE-1:0]                 flip_in,
    input  logic [3:0]                        neg_log_lr_in,
    output logic [$clog2(W_SIZE/CHUNK)-1:0]   mem_addr_out,
    output logic                              mem_rd_en_out,
    input  logic [CHUNK-1:0]                  mem_rd_data_in,
    output logic                              mem_wr_en_out,
    output logic [CHUNK-1:0]                  mem_wr_data_out,
    output logic                              busy_out,
    output logic                              done_out,
    output logic [$clog2(W_SIZE+1)-1:0]       flips_applied_out
);

    localparam int N_CHUNKS = W_SIZE / CHUNK;
    localparam int AW       = $clog2(N_CHUNKS);
    localparam int CW       = $clog2(W_SIZE + 1);
    localparam int LW       = $clog2(BRAM_LATENCY + 1);
    localparam int WAITS    = (BRAM_LATENCY > 1) ? BRAM_LATENCY - 2 : 0;
    localparam logic [AW-1:0] LAST      = AW'(N_CHUNKS - 1);
    localparam logic [LW-1:0] WAIT_INIT = LW'(WAITS);

    generate
        if (W_SIZE % CHUNK != 0) begin : g_bad_size
            $error("W_SIZE must be a multiple of CHUNK");
        end
        if (BRAM_LATENCY < 1) begin : g_bad_lat
            $error("BRAM_LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                         r_state;
    logic [31:0]                    r_lfsr;
    logic [N_CHUNKS-1:0][CHUNK-1:0] r_flip;
    logic [3:0]                     r_nlr;
    logic [CHUNK-1:0]               r_mask;
    logic [AW-1:0]                  r_idx;
    logic [AW-1:0]                  r_addr;
    logic [LW-1:0]                  r_wcnt;
    logic [CW-1:0]                  r_cnt;
    logic                           r_ready;
    logic                           r_busy;
    logic                           r_rd_en;
    logic                           r_wr_en;
    logic                           r_done;

    logic [46:0]      w_dbl;
    logic [CHUNK-1:0] w_keep;
    logic [CHUNK-1:0] w_fk;
    logic [CW-1:0]    w_pop;

    // w_dbl[k] = r_lfsr[k mod 32] for every lane window we can reach
    assign w_dbl = {r_lfsr[14:0], r_lfsr};

    always_comb begin
        w_keep = '1;
        for (int i = 0; i < CHUNK; i++) begin
            for (int j = 0; j < 15; j++) begin
                if (j < int'(r_nlr)) begin
                    w_keep[i] = w_keep[i] & w_dbl[(7 * i) % 32 + j];
                end
            end
        end
    end

    assign w_fk = r_flip[r_idx] & r_mask;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_pop = w_pop + CW'(w_fk[i]);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_lfsr  <= RANDOM_SEED;
            r_flip  <= '0;
            r_nlr   <= '0;
            r_mask  <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_wcnt  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (flip_valid_in) begin
                        r_flip  <= flip_in;
                        r_nlr   <= neg_log_lr_in;
                        r_idx   <= '0;
                        r_addr  <= '0;
                        r_cnt   <= '0;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_mask <= w_keep;
                    r_lfsr <= {r_lfsr[30:0],
                               r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
                    if (BRAM_LATENCY == 1) begin
                        r_wr_en <= 1'b1;
                        r_state <= S_WRITE;
                    end else begin
                        r_wcnt  <= WAIT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == '0) begin
                        r_wr_en <= 1'b1;
                        r_state <= S_WRITE;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    r_cnt <= r_cnt + w_pop;
                    if (r_idx == LAST) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_addr  <= r_idx + 1'b1;
                        r_rd_en <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign flip_ready_out    = r_ready;
    assign busy_out          = r_busy;
    assign done_out          = r_done;
    assign mem_addr_out      = r_addr;
    assign mem_rd_en_out     = r_rd_en;
    assign mem_wr_en_out     = r_wr_en;
    assign mem_wr_data_out   = r_wr_en ? (mem_rd_data_in ^ w_fk) : '0;
    assign flips_applied_out = r_cnt;

endmodule

// File: tb/tb_flip_update_sched.sv
// Randomized bench for flip_update_sched: two builds (latency 2 and 1),
// BRAM models, and a keep-mask reference computed from the LFSR rules.
module tb_flip_update_sched;

    localparam int W = 3072;
    localparam int C = 64;
    localparam int N = 48;
    localparam logic [31:0] SEED = 32'd1212;
    localparam logic [63:0] GARB = 64'hDEAD_BEEF_0BAD_F00D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         valid0, valid1;
    logic [W-1:0] flip;
    logic [3:0]   nlr;
    logic         ld;

    logic        ready0, rd0, wr0, busy0, done0;
    logic [5:0]  addr0;
    logic [63:0] rdata0, wdata0;
    logic [11:0] cnt0;
    logic        ready1, rd1, wr1, busy1, done1;
    logic [5:0]  addr1;
    logic [63:0] rdata1, wdata1;
    logic [11:0] cnt1;

    flip_update_sched #(.BRAM_LATENCY(2)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .flip_valid_in(valid0),
        .flip_ready_out(ready0), .flip_in(flip), .neg_log_lr_in(nlr),
        .mem_addr_out(addr0), .mem_rd_en_out(rd0), .mem_rd_data_in(rdata0),
        .mem_wr_en_out(wr0), .mem_wr_data_out(wdata0), .busy_out(busy0),
        .done_out(done0), .flips_applied_out(cnt0)
    );

    flip_update_sched #(.BRAM_LATENCY(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .flip_valid_in(valid1),
        .flip_ready_out(ready1), .flip_in(flip), .neg_log_lr_in(nlr),
        .mem_addr_out(addr1), .mem_rd_en_out(rd1), .mem_rd_data_in(rdata1),
        .mem_wr_en_out(wr1), .mem_wr_data_out(wdata1), .busy_out(busy1),
        .done_out(done1), .flips_applied_out(cnt1)
    );

    logic [63:0] mem0 [N];
    logic [63:0] mem1 [N];
    logic [63:0] init0 [N];
    logic [63:0] init1 [N];
    logic [63:0] exp_w [N];
    logic [63:0] tmp_w [N];
    int          exp_cnt;
    logic [63:0] p0a, p0b, p1a;
    int cyc = 0;
    int rq0[$], wa0[$], acc0[$], dn0[$], rq1[$], wa1[$], acc1[$], dn1[$];
    logic [63:0] wd0[$], wd1[$];
    int ov0, ov1;
    int errors = 0;
    int checks = 0;
    logic [31:0] m0, m1;

    assign rdata0 = p0b;
    assign rdata1 = p1a;

    // BRAM models with read pipelines and transaction logs
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ld) begin
            mem0 <= init0;
            mem1 <= init1;
            rq0.delete(); wa0.delete(); wd0.delete(); acc0.delete(); dn0.delete();
            rq1.delete(); wa1.delete(); wd1.delete(); acc1.delete(); dn1.delete();
            ov0 = 0;
            ov1 = 0;
        end else begin
            if (valid0 && ready0) acc0.push_back(cyc);
            if (done0) dn0.push_back(cyc - 1);
            if (rd0) rq0.push_back(int'(addr0));
            if (wr0) begin
                wa0.push_back(int'(addr0));
                wd0.push_back(wdata0);
                mem0[addr0] <= wdata0;
            end
            if (rd0 && wr0) ov0++;
            if (valid1 && ready1) acc1.push_back(cyc);
            if (done1) dn1.push_back(cyc - 1);
            if (rd1) rq1.push_back(int'(addr1));
            if (wr1) begin
                wa1.push_back(int'(addr1));
                wd1.push_back(wdata1);
                mem1[addr1] <= wdata1;
            end
            if (rd1 && wr1) ov1++;
        end
        p0a <= rd0 ? mem0[addr0] : GARB;
        p0b <= p0a;
        p1a <= rd1 ? mem1[addr1] : GARB;
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] r);
        return {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
    endfunction

    function automatic logic [63:0] keep_mask(input logic [31:0] r, input logic [3:0] n);
        logic [63:0] k;
        logic [63:0] d;
        logic [15:0] w;
        logic [15:0] m;
        m = 16'((32'd1 << n) - 1);
        for (int i = 0; i < 64; i++) begin
            d = {r, r} >> ((7 * i) % 32);
            w = d[15:0];
            k[i] = ((w & m) == m);
        end
        return k;
    endfunction

    task automatic model(input logic [63:0] init [N], input logic [W-1:0] f,
                         input logic [3:0] n, input int nch, inout logic [31:0] r);
        logic [63:0] fk;
        exp_cnt = 0;
        for (int c = 0; c < N; c++) begin
            if (c < nch) begin
                fk = f[c*C +: C] & keep_mask(r, n);
                exp_w[c] = init[c] ^ fk;
                exp_cnt += $countones(fk);
                r = lfsr_next(r);
            end else begin
                exp_w[c] = init[c];
            end
        end
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic load();
        @(negedge clk);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic start(input int d, input logic [W-1:0] f, input logic [3:0] n);
        @(negedge clk);
        flip = f;
        nlr = n;
        if (d == 0) valid0 = 1'b1;
        else valid1 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
        flip = ~f;
        nlr = ~n;
    endtask

    task automatic wait_idle(input int d, output bit to);
        to = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ((d == 0) ? ready0 : ready1) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ready0, busy0, rd0, wr0, done0} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 10000", {ready0, busy0, rd0, wr0, done0});
        end
        checks++;
        if ({cnt0, addr0, wdata0} !== '0) begin
            errors++;
            $display("FAIL reset_data: cnt %0d addr %0d wdata %h want zeros", cnt0, addr0, wdata0);
        end
        checks++;
        if ({ready1, busy1, rd1, wr1, done1} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl1: got %b want 10000", {ready1, busy1, rd1, wr1, done1});
        end
    endtask

    task automatic test_all_ones();
        bit to;
        for (int c = 0; c < N; c++) init0[c] = '0;
        load();
        model(init0, '1, 4'd0, N, m0);
        start(0, '1, 4'd0);
        wait_idle(0, to);
        checks++;
        if (to) begin errors++; $display("FAIL ones_timeout: no return to idle"); end
        checks++;
        if (wa0.size() != N || rq0.size() != N) begin
            errors++;
            $display("FAIL ones_count: writes %0d reads %0d want %0d", wa0.size(), rq0.size(), N);
        end
        for (int c = 0; c < wa0.size(); c++) begin
            checks++;
            if (wa0[c] != c || rq0[c] != c || wd0[c] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                errors++;
                $display("FAIL ones_word[%0d]: addr %0d raddr %0d data %h want addr %0d all ones",
                         c, wa0[c], rq0[c], wd0[c], c);
            end
        end
        checks++;
        if (cnt0 !== 12'd3072) begin
            errors++;
            $display("FAIL ones_flips: got %0d want 3072", cnt0);
        end
        checks++;
        if (dn0.size() != 1 || acc0.size() != 1 || dn0[0] - acc0[0] != 144) begin
            errors++;
            $display("FAIL ones_latency: done pulses %0d latency %0d want 1 and 144",
                     dn0.size(), dn0[0] - acc0[0]);
        end
        checks++;
        if (ov0 != 0) begin errors++; $display("FAIL ones_overlap: got %0d want 0", ov0); end
    endtask

    task automatic test_zero_flip();
        bit to;
        logic [3:0] n;
        n = 4'($urandom_range(0, 15));
        for (int c = 0; c < N; c++) init0[c] = {$urandom(), $urandom()};
        load();
        model(init0, '0, n, N, m0);
        start(0, '0, n);
        wait_idle(0, to);
        checks++;
        if (to || wa0.size() != N) begin
            errors++;
            $display("FAIL zero_writes: timeout %0d writes %0d want 0 and %0d", to, wa0.size(), N);
        end
        for (int c = 0; c < wa0.size(); c++) begin
            checks++;
            if (wd0[c] !== init0[wa0[c]]) begin
                errors++;
                $display("FAIL zero_word[%0d]: got %h want %h", c, wd0[c], init0[wa0[c]]);
            end
        end
        checks++;
        if (cnt0 !== 12'd0) begin errors++; $display("FAIL zero_flips: got %0d want 0", cnt0); end
    endtask

    task automatic test_random();
        bit to;
        logic [W-1:0] f;
        logic [3:0] nl [4];
        nl[0] = 4'd15;
        nl[1] = 4'd1;
        nl[2] = 4'($urandom_range(2, 4));
        nl[3] = 4'($urandom_range(5, 14));
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < N; c++) init0[c] = {$urandom(), $urandom()};
            f = rand_vec();
            load();
            model(init0, f, nl[t], N, m0);
            start(0, f, nl[t]);
            wait_idle(0, to);
            checks++;
            if (to || wa0.size() != N) begin
                errors++;
                $display("FAIL rand%0d_writes: timeout %0d writes %0d", t, to, wa0.size());
            end
            for (int c = 0; c < wa0.size(); c++) begin
                checks++;
                if (wa0[c] != c || wd0[c] !== exp_w[c]) begin
                    errors++;
                    $display("FAIL rand%0d_word[%0d]: addr %0d data %h want addr %0d data %h",
                             t, c, wa0[c], wd0[c], c, exp_w[c]);
                end
            end
            repeat (3) @(negedge clk);
            checks++;
            if (int'(cnt0) != exp_cnt) begin
                errors++;
                $display("FAIL rand%0d_flips: got %0d want %0d", t, cnt0, exp_cnt);
            end
            checks++;
            if (dn0.size() != 1 || dn0[0] - acc0[0] != 144) begin
                errors++;
                $display("FAIL rand%0d_latency: pulses %0d latency %0d want 1 and 144",
                         t, dn0.size(), dn0[0] - acc0[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int c1;
        logic [W-1:0] f;
        for (int c = 0; c < N; c++) init0[c] = {$urandom(), $urandom()};
        f = rand_vec();
        load();
        model(init0, f, 4'd2, N, m0);
        tmp_w = exp_w;
        c1 = exp_cnt;
        model(tmp_w, f, 4'd2, N, m0);
        @(negedge clk);
        flip = f;
        nlr = 4'd2;
        valid0 = 1'b1;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if (dn0.size() >= 2) break;
        end
        valid0 = 1'b0;
        wait_idle(0, to);
        checks++;
        if (to || acc0.size() != 2 || dn0.size() != 2) begin
            errors++;
            $display("FAIL b2b_accepts: timeout %0d accepts %0d dones %0d want 2 and 2",
                     to, acc0.size(), dn0.size());
        end
        checks++;
        if (acc0[1] - dn0[0] != 2) begin
            errors++;
            $display("FAIL b2b_gap: got %0d want 2", acc0[1] - dn0[0]);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (mem0[c] !== exp_w[c]) begin
                errors++;
                $display("FAIL b2b_mem[%0d]: got %h want %h", c, mem0[c], exp_w[c]);
            end
        end
        checks++;
        if (int'(cnt0) != exp_cnt) begin
            errors++;
            $display("FAIL b2b_flips: got %0d want %0d (first run %0d)", cnt0, exp_cnt, c1);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit hit;
        logic [W-1:0] f;
        for (int c = 0; c < N; c++) init0[c] = {$urandom(), $urandom()};
        f = rand_vec();
        load();
        model(init0, f, 4'd1, 10, m0);
        start(0, f, 4'd1);
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (acc0.size() > 0 && cyc - acc0[0] == 31) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit || wa0.size() != 10 || !busy0) begin
            errors++;
            $display("FAIL mid_pre: reached %0d writes %0d busy %0d want 1 10 1", hit, wa0.size(), busy0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ready0, busy0, rd0, wr0, done0} !== 5'b10000 || cnt0 !== 12'd0) begin
            errors++;
            $display("FAIL mid_abort: ctrl %b cnt %0d want 10000 and 0",
                     {ready0, busy0, rd0, wr0, done0}, cnt0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m0 = SEED;
        m1 = SEED;
        repeat (2) @(negedge clk);
        checks++;
        if (wa0.size() != 10) begin
            errors++;
            $display("FAIL mid_writes: got %0d want 10", wa0.size());
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (mem0[c] !== exp_w[c]) begin
                errors++;
                $display("FAIL mid_mem[%0d]: got %h want %h", c, mem0[c], exp_w[c]);
            end
        end
        for (int c = 0; c < N; c++) init0[c] = {$urandom(), $urandom()};
        f = rand_vec();
        load();
        model(init0, f, 4'd2, N, m0);
        start(0, f, 4'd2);
        wait_idle(0, to);
        for (int c = 0; c < N; c++) begin
            checks++;
            if (mem0[c] !== exp_w[c]) begin
                errors++;
                $display("FAIL reseed_mem[%0d]: got %h want %h", c, mem0[c], exp_w[c]);
            end
        end
        checks++;
        if (to || int'(cnt0) != exp_cnt) begin
            errors++;
            $display("FAIL reseed_flips: timeout %0d got %0d want %0d", to, cnt0, exp_cnt);
        end
    endtask

    task automatic test_latency1();
        bit to;
        logic [W-1:0] f;
        for (int c = 0; c < N; c++) init1[c] = {$urandom(), $urandom()};
        f = rand_vec();
        load();
        model(init1, f, 4'd1, N, m1);
        start(1, f, 4'd1);
        wait_idle(1, to);
        checks++;
        if (to || wa1.size() != N || rq1.size() != N) begin
            errors++;
            $display("FAIL lat1_writes: timeout %0d writes %0d reads %0d", to, wa1.size(), rq1.size());
        end
        for (int c = 0; c < wa1.size(); c++) begin
            checks++;
            if (wa1[c] != c || wd1[c] !== exp_w[c]) begin
                errors++;
                $display("FAIL lat1_word[%0d]: addr %0d data %h want addr %0d data %h",
                         c, wa1[c], wd1[c], c, exp_w[c]);
            end
        end
        checks++;
        if (int'(cnt1) != exp_cnt) begin
            errors++;
            $display("FAIL lat1_flips: got %0d want %0d", cnt1, exp_cnt);
        end
        checks++;
        if (dn1.size() != 1 || dn1[0] - acc1[0] != 96 || ov1 != 0) begin
            errors++;
            $display("FAIL lat1_timing: pulses %0d latency %0d overlap %0d want 1 96 0",
                     dn1.size(), dn1[0] - acc1[0], ov1);
        end
    endtask

    initial begin
        rst = 1'b1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        flip = '0;
        nlr = '0;
        ld = 1'b0;
        m0 = SEED;
        m1 = SEED;
        for (int c = 0; c < N; c++) begin
            init0[c] = '0;
            init1[c] = '0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_all_ones();
        test_zero_flip();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
